// File: rtl/clut_scheduler.sv
// clut_scheduler: per-pixel layer priority mux feeding the CLUT index, blank
// alignment pipeline, and a palette-bank switch deferred to the VBLANK rise.
module clut_scheduler #(
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter logic [7:0] BACKDROP    = 8'h00,
  parameter logic [7:0] BLANK_CODE  = 8'h00
) (
  input  logic       CLK_6M,
  input  logic       CLR,
  input  logic       HBLANK,
  input  logic       VBLANK,
  input  logic [7:0] TILE0_PIX,
  input  logic [7:0] TILE1_PIX,
  input  logic [7:0] SPR_PIX,
  input  logic [2:0] TILE0_PRI,
  input  logic [2:0] TILE1_PRI,
  input  logic [2:0] SPR_PRI,
  input  logic [2:0] LAYER_EN,
  input  logic       BANK_WR,
  input  logic       BANK_DIN,
  output logic       BANK_ACK,
  output logic [7:0] D,
  output logic       BANK,
  output logic       BLANK_OUT
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned PRI_W  = 3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [2:0]        opaque_c;
  logic              blank_c;
  logic [CODE_W-1:0] win_code_c;
  logic [PRI_W-1:0]  win_pri_c;
  logic              win_any_c;
  logic [CODE_W-1:0] sel_code_c;

  logic [CODE_W-1:0] s1_code;
  logic              s1_blank;
  logic              s2_blank;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       pend_bank;
  logic       pend_bank_nxt;
  logic       bank_nxt;
  logic       ack_nxt;
  logic       vb_prev;
  logic       vb_rise_c;

  // Opacity per layer: bit0 tile0, bit1 tile1, bit2 sprite.
  always_comb begin
    opaque_c    = '0;
    opaque_c[0] = LAYER_EN[0] && (TILE0_PIX != TRANSPARENT);
    opaque_c[1] = LAYER_EN[1] && (TILE1_PIX != TRANSPARENT);
    opaque_c[2] = LAYER_EN[2] && (SPR_PIX   != TRANSPARENT);
    blank_c     = HBLANK | VBLANK;
  end

  // Winner select: candidates visited in tie-break order, later ones must beat strictly.
  always_comb begin
    win_code_c = BACKDROP;
    win_pri_c  = '0;
    win_any_c  = 1'b0;
    if (opaque_c[2]) begin
      win_code_c = SPR_PIX;
      win_pri_c  = SPR_PRI;
      win_any_c  = 1'b1;
    end
    if (opaque_c[0] && (!win_any_c || (TILE0_PRI > win_pri_c))) begin
      win_code_c = TILE0_PIX;
      win_pri_c  = TILE0_PRI;
      win_any_c  = 1'b1;
    end
    if (opaque_c[1] && (!win_any_c || (TILE1_PRI > win_pri_c))) begin
      win_code_c = TILE1_PIX;
      win_pri_c  = TILE1_PRI;
      win_any_c  = 1'b1;
    end
    sel_code_c = blank_c ? BLANK_CODE : win_code_c;
  end

  // Two-stage index pipeline plus a three-deep blank delay for RGB alignment.
  always_ff @(posedge CLK_6M) begin
    if (!CLR) begin
      s1_code   <= BLANK_CODE;
      s1_blank  <= 1'b1;
      D         <= BLANK_CODE;
      s2_blank  <= 1'b1;
      BLANK_OUT <= 1'b1;
    end else begin
      s1_code   <= sel_code_c;
      s1_blank  <= blank_c;
      D         <= s1_code;
      s2_blank  <= s1_blank;
      BLANK_OUT <= s2_blank;
    end
  end

  assign vb_rise_c = VBLANK & ~vb_prev;

  // Bank FSM next-state: capture requests, apply on the VBLANK rise.
  always_comb begin
    state_nxt     = state;
    pend_bank_nxt = pend_bank;
    bank_nxt      = BANK;
    ack_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (BANK_WR) begin
          pend_bank_nxt = BANK_DIN;
          state_nxt     = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (vb_rise_c) begin
          bank_nxt  = BANK_WR ? BANK_DIN : pend_bank;
          ack_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (BANK_WR) begin
          pend_bank_nxt = BANK_DIN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bank FSM state and registered outputs; previous VBLANK resets high.
  always_ff @(posedge CLK_6M) begin
    if (!CLR) begin
      state     <= ST_IDLE;
      pend_bank <= 1'b0;
      BANK      <= 1'b0;
      BANK_ACK  <= 1'b0;
      vb_prev   <= 1'b1;
    end else begin
      state     <= state_nxt;
      pend_bank <= pend_bank_nxt;
      BANK      <= bank_nxt;
      BANK_ACK  <= ack_nxt;
      vb_prev   <= VBLANK;
    end
  end

endmodule

// File: tb/tb_clut_scheduler.sv
// Scoreboard bench for clut_scheduler: directed scenarios then random traffic,
// expected outputs derived from a cycle-history reference model.
module tb_clut_scheduler;

  localparam logic [7:0] TRANSP = 8'hFF;
  localparam logic [7:0] BKD    = 8'h00;
  localparam logic [7:0] BLK    = 8'h00;

  typedef struct {
    logic       clr, hb, vb;
    logic [7:0] t0, t1, sp;
    logic [2:0] p0, p1, ps;
    logic [2:0] en;
    logic       wr, din;
  } stim_t;

  typedef struct {
    logic [7:0] d;
    logic       bo, bank, ack;
    int         edge_n;
  } exp_t;

  logic       clk;
  logic       clr, hblank, vblank;
  logic [7:0] tile0_pix, tile1_pix, spr_pix;
  logic [2:0] tile0_pri, tile1_pri, spr_pri, layer_en;
  logic       bank_wr, bank_din;
  logic       bank_ack, bank, blank_out;
  logic [7:0] d;

  clut_scheduler dut (
    .CLK_6M(clk), .CLR(clr), .HBLANK(hblank), .VBLANK(vblank),
    .TILE0_PIX(tile0_pix), .TILE1_PIX(tile1_pix), .SPR_PIX(spr_pix),
    .TILE0_PRI(tile0_pri), .TILE1_PRI(tile1_pri), .SPR_PRI(spr_pri),
    .LAYER_EN(layer_en), .BANK_WR(bank_wr), .BANK_DIN(bank_din),
    .BANK_ACK(bank_ack), .D(d), .BANK(bank), .BLANK_OUT(blank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    edge_cnt = 0;

  // Reference model history and bank state
  stim_t h1, h2;
  logic  r1 = 1'b0, r2 = 1'b0;
  logic  m_bank = 1'b0, m_has = 1'b0, m_req = 1'b0, m_prev = 1'b1;

  function automatic logic [7:0] ref_code(stim_t s);
    logic [7:0] pix [3];
    logic [2:0] pri [3];
    int         rank [3];
    int         best;
    logic [7:0] c;
    if (s.hb || s.vb) return BLK;
    pix[0] = s.t0; pri[0] = s.p0; rank[0] = 1;
    pix[1] = s.t1; pri[1] = s.p1; rank[1] = 0;
    pix[2] = s.sp; pri[2] = s.ps; rank[2] = 2;
    best = -1;
    c    = BKD;
    for (int i = 0; i < 3; i++) begin
      if (s.en[i] && pix[i] != TRANSP && (int'(pri[i]) * 3 + rank[i]) > best) begin
        best = int'(pri[i]) * 3 + rank[i];
        c    = pix[i];
      end
    end
    return c;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s.clr = 1'b1; s.hb = 1'b0; s.vb = 1'b0;
    s.t0 = TRANSP; s.t1 = TRANSP; s.sp = TRANSP;
    s.p0 = 3'd0; s.p1 = 3'd0; s.ps = 3'd0;
    s.en = 3'b111; s.wr = 1'b0; s.din = 1'b0;
    return s;
  endfunction

  // Apply one cycle of inputs, predict the outputs after the coming edge, push them.
  task automatic step(input stim_t s);
    exp_t e;
    logic rise;
    clr = s.clr; hblank = s.hb; vblank = s.vb;
    tile0_pix = s.t0; tile1_pix = s.t1; spr_pix = s.sp;
    tile0_pri = s.p0; tile1_pri = s.p1; spr_pri = s.ps;
    layer_en = s.en; bank_wr = s.wr; bank_din = s.din;

    e.edge_n = edge_cnt;
    e.d   = (!s.clr || !r1) ? BLK : ref_code(h1);
    e.bo  = (!s.clr || !r1 || !r2) ? 1'b1 : (h2.hb | h2.vb);
    e.ack = 1'b0;
    if (!s.clr) begin
      m_bank = 1'b0; m_has = 1'b0; m_req = 1'b0; m_prev = 1'b1;
    end else begin
      rise = s.vb && !m_prev;
      if (m_has && rise) begin
        m_bank = s.wr ? s.din : m_req;
        m_has  = 1'b0;
        e.ack  = 1'b1;
      end else if (s.wr) begin
        m_req = s.din;
        m_has = 1'b1;
      end
      m_prev = s.vb;
    end
    e.bank = m_bank;
    q.push_back(e);

    h2 = h1; h1 = s; r2 = r1; r1 = s.clr;
    edge_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp, input int n);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %02h expected %02h", name, n, act, exp);
  endtask

  // Monitor: one expected record per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty at time %0t", $time);
      end else begin
        e = q.pop_front();
        chk("d",         d,               e.d,               e.edge_n);
        chk("blank_out", 8'(blank_out),   8'(e.bo),          e.edge_n);
        chk("bank",      8'(bank),        8'(e.bank),        e.edge_n);
        chk("bank_ack",  8'(bank_ack),    8'(e.ack),         e.edge_n);
      end
    end
  end

  logic vb_r = 1'b0, hb_r = 1'b0;

  function automatic stim_t rnd_stim();
    stim_t s;
    s = base();
    if ($urandom_range(15) == 0) vb_r = ~vb_r;
    if ($urandom_range(7) == 0)  hb_r = ~hb_r;
    s.clr = ($urandom_range(99) != 0);
    s.vb  = vb_r;
    s.hb  = hb_r;
    s.t0  = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
    s.t1  = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
    s.sp  = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
    s.p0  = 3'($urandom_range(7));
    s.p1  = 3'($urandom_range(7));
    s.ps  = 3'($urandom_range(7));
    s.en  = 3'($urandom_range(7));
    s.wr  = ($urandom_range(5) == 0);
    s.din = 1'($urandom_range(1));
    return s;
  endfunction

  // Stimulus: directed scenarios then random cycles.
  initial begin
    stim_t s;
    s = base();
    // reset with VBLANK already high; request after release must not see a false edge
    s.clr = 1'b0; s.vb = 1'b1; repeat (3) step(s);
    s.clr = 1'b1; s.wr = 1'b1; s.din = 1'b1; step(s);
    s.wr = 1'b0; repeat (3) step(s);
    s.vb = 1'b0; repeat (2) step(s);
    s.vb = 1'b1; step(s);
    s.vb = 1'b0; step(s);
    // priority
    s.t0 = 8'h12; s.p0 = 3'd3; s.t1 = 8'h34; s.p1 = 3'd5; s.sp = 8'h56; s.ps = 3'd5;
    repeat (4) step(s);
    s.en = 3'b011; repeat (4) step(s);
    // transparency
    s.en = 3'b111; s.t0 = TRANSP; s.t1 = TRANSP; s.sp = TRANSP; repeat (3) step(s);
    s.t1 = 8'h07; repeat (3) step(s);
    // blanking
    s.t1 = TRANSP; s.sp = 8'hA5; s.ps = 3'd7; repeat (3) step(s);
    s.hb = 1'b1; repeat (4) step(s);
    s.hb = 1'b0; repeat (5) step(s);
    // bank: reset to 0, three writes, last wins, single ACK on the rise
    s.clr = 1'b0; step(s);
    s.clr = 1'b1; step(s);
    s.wr = 1'b1; s.din = 1'b1; step(s);
    s.wr = 1'b0; step(s);
    s.wr = 1'b1; s.din = 1'b0; step(s);
    s.wr = 1'b0; step(s);
    s.wr = 1'b1; s.din = 1'b1; step(s);
    s.wr = 1'b0; repeat (2) step(s);
    s.vb = 1'b1; step(s);
    s.vb = 1'b0; repeat (2) step(s);
    // write on a rise cycle from idle: applied only at the next frame's rise
    s.vb = 1'b1; s.wr = 1'b1; s.din = 1'b0; step(s);
    s.wr = 1'b0; repeat (3) step(s);
    s.vb = 1'b0; repeat (2) step(s);
    s.vb = 1'b1; step(s);
    s.vb = 1'b0; step(s);
    // write the current value: still completes with an ACK
    s.wr = 1'b1; s.din = 1'b0; step(s);
    s.wr = 1'b0; step(s);
    s.vb = 1'b1; step(s);
    s.vb = 1'b0; step(s);
    // reset while pending discards the request
    s.wr = 1'b1; s.din = 1'b1; step(s);
    s.wr = 1'b0; step(s);
    s.clr = 1'b0; step(s);
    s.clr = 1'b1; repeat (2) step(s);
    s.vb = 1'b1; repeat (2) step(s);
    s.vb = 1'b0; repeat (2) step(s);
    // random traffic
    repeat (3000) step(rnd_stim());

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
